// File: rtl/npu_pkg.sv
// Shared NPU definitions: datapath widths, writeback FSM states and the
// saturating 8-bit adder used to apply the per-layer bias.
package npu_pkg;

  localparam int NPU_DATA_W = 8;
  localparam int NPU_ADDR_W = 10;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_FIRST,
    WR_SECOND
  } wb_state_t;

  // Signed 8-bit add with saturation to [-128, 127]. The 9-bit sum overflows
  // exactly when its top two bits disagree; bit 8 then gives the true sign.
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] t;
    t = {a[7], a} + {b[7], b};
    if (t[8] != t[7]) begin
      sat_add8 = t[8] ? 8'h80 : 8'h7F;
    end else begin
      sat_add8 = t[7:0];
    end
  endfunction

endpackage

// File: rtl/wb_pair_fifo.sv
// Synchronous FIFO holding result pairs for the writeback stage.
// Head entry is visible combinationally on o_rdata; push and pop in the
// same cycle are supported, including when full.
module wb_pair_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  // Pointers carry one extra wrap bit to tell full from empty.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (i_push) wr_ptr <= wr_ptr + 1'b1;
      if (i_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage array; contents need no reset since the pointers gate visibility.
  always_ff @(posedge i_clk) begin
    if (i_push) mem[wr_ptr[AW-1:0]] <= i_wdata;
  end

  assign o_rdata = mem[rd_ptr[AW-1:0]];
  assign o_empty = (wr_ptr == rd_ptr);
  assign o_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/conv_writeback.sv
// Convolution writeback: buffers result pairs from the convolve stage, adds
// the per-layer bias with signed saturation and writes both results to the
// scratchpad over a valid/ready port.
// Optional feature: define WB_RELU_EN to clamp negative results to zero.
module conv_writeback
  import npu_pkg::*;
#(
  parameter int DATA_W     = NPU_DATA_W,
  parameter int ADDR_W     = NPU_ADDR_W,
  parameter int PAIR_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_sum1,
  input  logic [DATA_W-1:0] i_sum2,
  input  logic [ADDR_W-1:0] i_dest_addr1,
  input  logic [ADDR_W-1:0] i_dest_addr2,
  input  logic [DATA_W-1:0] i_bias,
  output logic              o_ready,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ready,
  output logic              o_busy,
  output logic              o_overflow,
  output logic [15:0]       o_wr_count
);

  localparam int PAIR_W = 2*DATA_W + 2*ADDR_W;

  wb_state_t         state_q;
  wb_state_t         state_d;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              xfer;
  logic [PAIR_W-1:0] fifo_wdata;
  logic [PAIR_W-1:0] head;
  logic [DATA_W-1:0] head_sum1;
  logic [DATA_W-1:0] head_sum2;
  logic [ADDR_W-1:0] head_addr1;
  logic [ADDR_W-1:0] head_addr2;
  logic [DATA_W-1:0] res1;
  logic [DATA_W-1:0] res2;
  logic [ADDR_W-1:0] addr1_q;
  logic [ADDR_W-1:0] addr2_q;
  logic [DATA_W-1:0] data1_q;
  logic [DATA_W-1:0] data2_q;

  assign fifo_wdata = {i_sum1, i_sum2, i_dest_addr1, i_dest_addr2};
  assign head_sum1  = head[PAIR_W-1 -: DATA_W];
  assign head_sum2  = head[PAIR_W-DATA_W-1 -: DATA_W];
  assign head_addr1 = head[2*ADDR_W-1 -: ADDR_W];
  assign head_addr2 = head[ADDR_W-1:0];

  // A full FIFO still accepts a pair in a cycle where the head is popped,
  // so o_ready also covers that case and no pair is dropped needlessly.
  assign o_ready = ~fifo_full | pop;
  assign push    = i_valid & o_ready;
  assign xfer    = o_mem_we & i_mem_ready;
  assign o_busy  = (state_q != WR_IDLE) | ~fifo_empty;

  wb_pair_fifo #(
    .WIDTH (PAIR_W),
    .DEPTH (PAIR_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (push),
    .i_wdata (fifo_wdata),
    .i_pop   (pop),
    .o_rdata (head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  // Bias the head pair; i_bias is used in the cycle the head is popped.
  always_comb begin
    res1 = sat_add8(head_sum1, i_bias);
    res2 = sat_add8(head_sum2, i_bias);
`ifdef WB_RELU_EN
    if (res1[DATA_W-1]) res1 = '0;
    if (res2[DATA_W-1]) res2 = '0;
`endif
  end

  // FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= WR_IDLE;
    else       state_q <= state_d;
  end

  // Next state, pop decision and write-port drive.
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    case (state_q)
      WR_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = WR_FIRST;
        end
      end
      WR_FIRST: begin
        o_mem_we    = 1'b1;
        o_mem_addr  = addr1_q;
        o_mem_wdata = data1_q;
        if (i_mem_ready) state_d = WR_SECOND;
      end
      WR_SECOND: begin
        o_mem_we    = 1'b1;
        o_mem_addr  = addr2_q;
        o_mem_wdata = data2_q;
        if (i_mem_ready) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = WR_FIRST;
          end else begin
            state_d = WR_IDLE;
          end
        end
      end
      default: state_d = WR_IDLE;
    endcase
  end

  // Latch the popped pair with its biased results for the two writes.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      addr1_q <= '0;
      addr2_q <= '0;
      data1_q <= '0;
      data2_q <= '0;
    end else if (pop) begin
      addr1_q <= head_addr1;
      addr2_q <= head_addr2;
      data1_q <= res1;
      data2_q <= res2;
    end
  end

  // Sticky overflow flag and completed-write counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_overflow <= 1'b0;
      o_wr_count <= '0;
    end else begin
      if (i_valid && !o_ready) o_overflow <= 1'b1;
      if (xfer)                o_wr_count <= o_wr_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_conv_writeback.sv
// Self-checking bench for conv_writeback: a queue-based model of the pair
// buffer and pending writes is compared every cycle, and directed scenarios
// pin the model with hand-computed write addresses and data.
module tb_conv_writeback;

  localparam int DEPTH = 4;

`ifdef WB_RELU_EN
  localparam logic [7:0] EXP_NEG86 = 8'h00;
  localparam logic [7:0] EXP_SAT80 = 8'h00;
  localparam logic [7:0] EXP_NEGF5 = 8'h00;
`else
  localparam logic [7:0] EXP_NEG86 = 8'h86;
  localparam logic [7:0] EXP_SAT80 = 8'h80;
  localparam logic [7:0] EXP_NEGF5 = 8'hF5;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [7:0]  sum1, sum2, bias;
  logic [9:0]  da1, da2;
  logic        mem_ready;
  logic        o_ready, o_mem_we, o_busy, o_overflow;
  logic [9:0]  o_mem_addr;
  logic [7:0]  o_mem_wdata;
  logic [15:0] o_wr_count;

  int n_cmp = 0;
  int n_err = 0;
  int we_run = 0;
  int we_run_max = 0;

  conv_writeback #(
    .DATA_W     (8),
    .ADDR_W     (10),
    .PAIR_DEPTH (DEPTH)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_valid      (valid),
    .i_sum1       (sum1),
    .i_sum2       (sum2),
    .i_dest_addr1 (da1),
    .i_dest_addr2 (da2),
    .i_bias       (bias),
    .o_ready      (o_ready),
    .o_mem_we     (o_mem_we),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .i_mem_ready  (mem_ready),
    .o_busy       (o_busy),
    .o_overflow   (o_overflow),
    .o_wr_count   (o_wr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [7:0] s1;
    logic [7:0] s2;
    logic [9:0] a1;
    logic [9:0] a2;
  } pair_t;

  typedef struct {
    logic [9:0] a;
    logic [7:0] d;
  } wr_t;

  pair_t       mq[$];
  wr_t         mw[$];
  logic [15:0] m_cnt = '0;
  logic        m_ovf = 1'b0;

  function automatic logic [7:0] m_res(input logic [7:0] s, input logic [7:0] b);
    int t;
    t = int'($signed(s)) + int'($signed(b));
    if (t > 127)  t = 127;
    if (t < -128) t = -128;
`ifdef WB_RELU_EN
    if (t < 0) t = 0;
`endif
    return 8'(t);
  endfunction

  // Compare on the falling edge, then advance the model with the inputs the
  // DUT will see at the next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      begin
        bit         e_we, popn, e_rdy;
        logic [9:0] e_addr;
        logic [7:0] e_data;
        pair_t      p;
        wr_t        w1, w2;
        if (rst) begin
          mq.delete();
          mw.delete();
          m_cnt = '0;
          m_ovf = 1'b0;
        end
        e_we   = (mw.size() > 0);
        e_addr = e_we ? mw[0].a : 10'd0;
        e_data = e_we ? mw[0].d : 8'd0;
        popn   = !rst && (mq.size() > 0) &&
                 ((mw.size() == 0) || (mw.size() == 1 && mem_ready));
        e_rdy  = (mq.size() < DEPTH) || popn;
        chk("mem_we",   32'(o_mem_we),    32'(e_we));
        chk("mem_addr", 32'(o_mem_addr),  32'(e_addr));
        chk("mem_data", 32'(o_mem_wdata), 32'(e_data));
        chk("ready",    32'(o_ready),     32'(e_rdy));
        chk("busy",     32'(o_busy),      32'((mw.size() > 0) || (mq.size() > 0)));
        chk("overflow", 32'(o_overflow),  32'(m_ovf));
        chk("wr_count", 32'(o_wr_count),  32'(m_cnt));
        if (o_mem_we) we_run++; else we_run = 0;
        if (we_run > we_run_max) we_run_max = we_run;
        if (!rst) begin
          if (e_we && mem_ready) begin
            void'(mw.pop_front());
            m_cnt = m_cnt + 16'd1;
          end
          if (popn) begin
            p = mq.pop_front();
            w1.a = p.a1; w1.d = m_res(p.s1, bias);
            w2.a = p.a2; w2.d = m_res(p.s2, bias);
            mw.push_back(w1);
            mw.push_back(w2);
          end
          if (valid) begin
            if (e_rdy) begin
              p.s1 = sum1; p.s2 = sum2; p.a1 = da1; p.a2 = da2;
              mq.push_back(p);
            end else begin
              m_ovf = 1'b1;
            end
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_pair(input logic [7:0] s1, input logic [7:0] s2,
                            input logic [9:0] a1, input logic [9:0] a2);
    valid = 1'b1;
    sum1  = s1;
    sum2  = s2;
    da1   = a1;
    da2   = a2;
    @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  task automatic expect_write(input logic [9:0] a, input logic [7:0] d);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (o_mem_we && mem_ready) begin
        seen = 1'b1;
        chk("wr_addr", 32'(o_mem_addr), 32'(a));
        chk("wr_data", 32'(o_mem_wdata), 32'(d));
      end
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL wr_timeout: no write seen, expected addr %0h data %0h", a, d);
    end
  endtask

  task automatic wait_we(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (o_mem_we) seen = 1'b1;
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL we_timeout: o_mem_we never rose");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    bit         seen;
    logic [9:0] h_addr;
    logic [7:0] h_data;

    rst = 1'b1; valid = 1'b0; sum1 = '0; sum2 = '0; da1 = '0; da2 = '0;
    bias = '0; mem_ready = 1'b1;
    step(2);
    chk("rst_ready",  32'(o_ready),    32'd1);
    chk("rst_we",     32'(o_mem_we),   32'd0);
    chk("rst_busy",   32'(o_busy),     32'd0);
    chk("rst_ovf",    32'(o_overflow), 32'd0);
    chk("rst_count",  32'(o_wr_count), 32'd0);
    rst = 1'b0;
    step(1);

    // 1: single pair, bias 0
    drive_pair(8'h05, 8'h07, 10'h010, 10'h011);
    expect_write(10'h010, 8'h05);
    expect_write(10'h011, 8'h07);
    step(2);
    chk("t1_count", 32'(o_wr_count), 32'd2);

    // 2: saturation
    bias = 8'h05;
    drive_pair(8'h7E, 8'h81, 10'h020, 10'h021);
    expect_write(10'h020, 8'h7F);
    expect_write(10'h021, EXP_NEG86);
    step(1);
    bias = 8'hF0;
    drive_pair(8'h81, 8'h05, 10'h022, 10'h023);
    expect_write(10'h022, EXP_SAT80);
    expect_write(10'h023, EXP_NEGF5);
    step(1);
    bias = 8'h00;

    // 3: backpressure, outputs held while ready is low
    mem_ready = 1'b0;
    drive_pair(8'h11, 8'h22, 10'h030, 10'h031);
    wait_we(seen);
    h_addr = o_mem_addr;
    h_data = o_mem_wdata;
    chk("t3_addr", 32'(h_addr), 32'h030);
    chk("t3_data", 32'(h_data), 32'h11);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t3_hold_we",   32'(o_mem_we),    32'd1);
      chk("t3_hold_addr", 32'(o_mem_addr),  32'(h_addr));
      chk("t3_hold_data", 32'(o_mem_wdata), 32'(h_data));
    end
    @(posedge clk);
    #1;
    mem_ready = 1'b1;
    expect_write(10'h030, 8'h11);
    expect_write(10'h031, 8'h22);
    step(2);

    // 4: overflow; one pair goes to the write stage, four fill the FIFO, the sixth drops
    mem_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive_pair(8'(8'h10 + i), 8'(8'h20 + i), 10'(10'h100 + 2*i), 10'(10'h101 + 2*i));
    end
    chk("t4_ovf",   32'(o_overflow), 32'd1);
    chk("t4_ready", 32'(o_ready),    32'd0);
    chk("t4_addr",  32'(o_mem_addr), 32'h100);
    mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      expect_write(10'(10'h100 + 2*i), 8'(8'h10 + i));
      expect_write(10'(10'h101 + 2*i), 8'(8'h20 + i));
    end
    step(3);
    chk("t4_count", 32'(o_wr_count), 32'd18);
    chk("t4_idle",  32'(o_busy),     32'd0);

    // 5: back-to-back pairs stream without bubbles
    we_run_max = 0;
    drive_pair(8'h01, 8'h02, 10'h200, 10'h201);
    drive_pair(8'h03, 8'h04, 10'h202, 10'h203);
    drive_pair(8'h05, 8'h06, 10'h204, 10'h205);
    step(10);
    chk("t5_run",   32'(we_run_max), 32'd6);
    chk("t5_count", 32'(o_wr_count), 32'd24);

    // 6: reset while the first write is pending with two pairs queued
    mem_ready = 1'b0;
    drive_pair(8'h31, 8'h32, 10'h300, 10'h301);
    drive_pair(8'h33, 8'h34, 10'h302, 10'h303);
    drive_pair(8'h35, 8'h36, 10'h304, 10'h305);
    chk("t6_we",   32'(o_mem_we),   32'd1);
    chk("t6_addr", 32'(o_mem_addr), 32'h300);
    rst = 1'b1;
    #1;
    chk("t6_rst_we",    32'(o_mem_we),    32'd0);
    chk("t6_rst_addr",  32'(o_mem_addr),  32'd0);
    chk("t6_rst_data",  32'(o_mem_wdata), 32'd0);
    chk("t6_rst_ready", 32'(o_ready),     32'd1);
    chk("t6_rst_busy",  32'(o_busy),      32'd0);
    chk("t6_rst_ovf",   32'(o_overflow),  32'd0);
    chk("t6_rst_count", 32'(o_wr_count),  32'd0);
    step(2);
    rst = 1'b0;
    mem_ready = 1'b1;
    we_run_max = 0;
    step(10);
    chk("t6_no_write", 32'(we_run_max), 32'd0);
    chk("t6_count",    32'(o_wr_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
